universal_gate_mux: RTL and testbench

- Builds the universal gates NAND and NOR purely from 2:1 multiplexers.
- Operates bitwise on two WIDTH-bit operands and registers the results.
- Used as a small registered logic primitive and as a teaching/reference block for mux-based logic synthesis.
- Single clock domain.

---
 rtl/universal_gate_pkg.sv | 17 +
 rtl/universal_gate_mux_mux2.sv | 11 +
 rtl/universal_gate_mux.sv | 137 +++++++++++++
 tb/tb_universal_gate_mux.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/universal_gate_pkg.sv
// Shared constants and operation enumeration for the mux-built universal gate block.
package universal_gate_pkg;

  localparam int unsigned UGM_MAX_WIDTH = 64;

  localparam logic [UGM_MAX_WIDTH-1:0] UGM_RST_VAL = '0;

  // Gate selector used by scoreboards and reference models.
  typedef enum logic [2:0] {
    OpNand = 3'd0,
    OpNor  = 3'd1,
    OpAnd  = 3'd2,
    OpOr   = 3'd3,
    OpXor  = 3'd4
  } ugm_op_t;

endpackage

// File: rtl/universal_gate_mux_mux2.sv
// 1-bit 2:1 multiplexer, the only logic primitive used by universal_gate_mux.
module mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/universal_gate_mux.sv
// Registered bitwise NAND/NOR built purely from mux2 instances.
// Define UNIVERSAL_GATE_MUX_EXT_EN to add registered AND/OR/XOR outputs.
module universal_gate_mux
  import universal_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s_nand,
  output logic [WIDTH-1:0] s_nor,
`ifdef UNIVERSAL_GATE_MUX_EXT_EN
  output logic [WIDTH-1:0] s_and,
  output logic [WIDTH-1:0] s_or,
  output logic [WIDTH-1:0] s_xor,
`endif
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > UGM_MAX_WIDTH) begin : gen_bad_width
    $error("universal_gate_mux: WIDTH out of range 1..64");
  end

  localparam logic [WIDTH-1:0] RstVal = UGM_RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] nand_c;
  logic [WIDTH-1:0] nor_c;
  logic [WIDTH-1:0] s_nand_q;
  logic [WIDTH-1:0] s_nor_q;
  logic             out_valid_q;

`ifdef UNIVERSAL_GATE_MUX_EXT_EN
  logic [WIDTH-1:0] and_c;
  logic [WIDTH-1:0] or_c;
  logic [WIDTH-1:0] xor_c;
  logic [WIDTH-1:0] s_and_q;
  logic [WIDTH-1:0] s_or_q;
  logic [WIDTH-1:0] s_xor_q;
`endif

  for (genvar i = 0; i < int'(WIDTH); i++) begin : gen_bit
    // Inverter: select between constants using b as the select.
    mux2 u_inv (
      .sel (b[i]),
      .d0  (1'b1),
      .d1  (1'b0),
      .y   (nb[i])
    );

    mux2 u_nand (
      .sel (a[i]),
      .d0  (1'b1),
      .d1  (nb[i]),
      .y   (nand_c[i])
    );

    mux2 u_nor (
      .sel (a[i]),
      .d0  (nb[i]),
      .d1  (1'b0),
      .y   (nor_c[i])
    );

`ifdef UNIVERSAL_GATE_MUX_EXT_EN
    mux2 u_and (
      .sel (a[i]),
      .d0  (1'b0),
      .d1  (b[i]),
      .y   (and_c[i])
    );

    mux2 u_or (
      .sel (a[i]),
      .d0  (b[i]),
      .d1  (1'b1),
      .y   (or_c[i])
    );

    mux2 u_xor (
      .sel (a[i]),
      .d0  (b[i]),
      .d1  (nb[i]),
      .y   (xor_c[i])
    );
`endif
  end

  // Results load only on valid, so garbage on a/b while idle never reaches the outputs.
`ifdef UNIVERSAL_GATE_MUX_EXT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_nand_q    <= RstVal;
      s_nor_q     <= RstVal;
      s_and_q     <= RstVal;
      s_or_q      <= RstVal;
      s_xor_q     <= RstVal;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        s_nand_q <= nand_c;
        s_nor_q  <= nor_c;
        s_and_q  <= and_c;
        s_or_q   <= or_c;
        s_xor_q  <= xor_c;
      end
    end
  end

  assign s_and = s_and_q;
  assign s_or  = s_or_q;
  assign s_xor = s_xor_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_nand_q    <= RstVal;
      s_nor_q     <= RstVal;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        s_nand_q <= nand_c;
        s_nor_q  <= nor_c;
      end
    end
  end
`endif

  assign s_nand    = s_nand_q;
  assign s_nor     = s_nor_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_universal_gate_mux.sv
// Self-checking bench for universal_gate_mux (WIDTH=8); covers UNIVERSAL_GATE_MUX_EXT_EN when defined.
module tb_universal_gate_mux;
  import universal_gate_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] s_nand;
  logic [W-1:0] s_nor;
  logic         out_valid;
`ifdef UNIVERSAL_GATE_MUX_EXT_EN
  logic [W-1:0] s_and;
  logic [W-1:0] s_or;
  logic [W-1:0] s_xor;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the outputs should hold after the latest edge.
  logic [W-1:0] m_nand, m_nor, m_and, m_or, m_xor;
  logic         m_valid;

  universal_gate_mux #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .s_nand    (s_nand),
    .s_nor     (s_nor),
`ifdef UNIVERSAL_GATE_MUX_EXT_EN
    .s_and     (s_and),
    .s_or      (s_or),
    .s_xor     (s_xor),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(ugm_op_t op, logic [W-1:0] x, logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) begin
      int ones;
      ones = int'(x[i]) + int'(y[i]);
      case (op)
        OpNand:  r[i] = (ones != 2);
        OpNor:   r[i] = (ones == 0);
        OpAnd:   r[i] = (ones == 2);
        OpOr:    r[i] = (ones != 0);
        default: r[i] = (ones == 1);
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_nand = '0; m_nor = '0; m_and = '0; m_or = '0; m_xor = '0; m_valid = 1'b0;
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising edge, settle 1ns.
  task automatic cycle(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib);
    @(negedge clk);
    in_valid = v;
    a = ia;
    b = ib;
    @(posedge clk);
    if (rst_n) begin
      m_valid = v;
      if (v) begin
        m_nand = ref_op(OpNand, ia, ib);
        m_nor  = ref_op(OpNor, ia, ib);
        m_and  = ref_op(OpAnd, ia, ib);
        m_or   = ref_op(OpOr, ia, ib);
        m_xor  = ref_op(OpXor, ia, ib);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({s_nand, s_nor, out_valid} !== {8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got nand=%h nor=%h v=%b want 00 00 0", s_nand, s_nor, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h00, 8'h00);
    n_checks++;
    if ({s_nand, s_nor, out_valid} !== {8'hFF, 8'hFF, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_preload: got nand=%h nor=%h v=%b want ff ff 1", s_nand, s_nor, out_valid);
    end
    // Assert reset mid-cycle, well away from any clock edge.
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({s_nand, s_nor, out_valid} !== {8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got nand=%h nor=%h v=%b want 00 00 0", s_nand, s_nor, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab_tab [4];
    logic [1:0] nn_tab [4];
    ab_tab = '{2'b00, 2'b01, 2'b11, 2'b10};
    nn_tab = '{2'b11, 2'b10, 2'b00, 2'b10};
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, {W{ab_tab[k][1]}}, {W{ab_tab[k][0]}});
      n_checks++;
      if ({s_nand, s_nor, out_valid} !== {{W{nn_tab[k][1]}}, {W{nn_tab[k][0]}}, 1'b1}) begin
        n_fail++;
        $display("FAIL truth_table ab=%b: got nand=%h nor=%h v=%b want nand=%h nor=%h v=1",
                 ab_tab[k], s_nand, s_nor, out_valid, {W{nn_tab[k][1]}}, {W{nn_tab[k][0]}});
      end
    end
  endtask

  task automatic test_hold();
    cycle(1'b1, 8'h00, 8'h00);
    cycle(1'b0, 8'hFF, 8'hFF);
    n_checks++;
    if ({s_nand, s_nor, out_valid} !== {8'hFF, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL hold: got nand=%h nor=%h v=%b want ff ff 0", s_nand, s_nor, out_valid);
    end
    cycle(1'b0, 'x, 'x);
    n_checks++;
    if ({s_nand, s_nor, out_valid} !== {8'hFF, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_x: got nand=%h nor=%h v=%b want ff ff 0", s_nand, s_nor, out_valid);
    end
  endtask

  task automatic test_wide_vector();
    cycle(1'b1, 8'hF0, 8'hCC);
    n_checks++;
    if ({s_nand, s_nor, out_valid} !== {8'h3F, 8'h03, 1'b1}) begin
      n_fail++;
      $display("FAIL wide_vector: got nand=%h nor=%h v=%b want 3f 03 1", s_nand, s_nor, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    cycle(1'b1, 8'h00, 8'h0F);
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if ({s_nand, s_nor, out_valid} !== {8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midstream_drop: got nand=%h nor=%h v=%b want 00 00 0",
               s_nand, s_nor, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 8'h00);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midstream_idle: got v=%b want 0", out_valid);
    end
    cycle(1'b1, 8'hFF, 8'hFF);
    n_checks++;
    if ({s_nand, s_nor, out_valid} !== {8'h00, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_midstream_first: got nand=%h nor=%h v=%b want 00 00 1",
               s_nand, s_nor, out_valid);
    end
    cycle(1'b1, 8'h00, 8'h00);
    n_checks++;
    if ({s_nand, s_nor, out_valid} !== {8'hFF, 8'hFF, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_midstream_next: got nand=%h nor=%h v=%b want ff ff 1",
               s_nand, s_nor, out_valid);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int k = 0; k < 300; k++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      cycle(v, W'($urandom), W'($urandom));
      n_checks++;
      if ({s_nand, s_nor, out_valid} !== {m_nand, m_nor, m_valid}) begin
        n_fail++;
        $display("FAIL random[%0d]: got nand=%h nor=%h v=%b want nand=%h nor=%h v=%b",
                 k, s_nand, s_nor, out_valid, m_nand, m_nor, m_valid);
      end
`ifdef UNIVERSAL_GATE_MUX_EXT_EN
      n_checks++;
      if ({s_and, s_or, s_xor} !== {m_and, m_or, m_xor}) begin
        n_fail++;
        $display("FAIL random_ext[%0d]: got and=%h or=%h xor=%h want and=%h or=%h xor=%h",
                 k, s_and, s_or, s_xor, m_and, m_or, m_xor);
      end
`endif
    end
  endtask

  task automatic test_ext();
`ifdef UNIVERSAL_GATE_MUX_EXT_EN
    cycle(1'b1, 8'hF0, 8'hCC);
    n_checks++;
    if ({s_and, s_or, s_xor} !== {8'hC0, 8'hFC, 8'h3C}) begin
      n_fail++;
      $display("FAIL ext_vector: got and=%h or=%h xor=%h want c0 fc 3c", s_and, s_or, s_xor);
    end
    cycle(1'b0, 8'h00, 8'h00);
    n_checks++;
    if ({s_and, s_or, s_xor, out_valid} !== {8'hC0, 8'hFC, 8'h3C, 1'b0}) begin
      n_fail++;
      $display("FAIL ext_hold: got and=%h or=%h xor=%h v=%b want c0 fc 3c 0",
               s_and, s_or, s_xor, out_valid);
    end
`else
    $display("note: extended gate outputs not built");
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_truth_table();
    test_hold();
    test_wide_vector();
    test_reset_midstream();
    test_ext();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
